// File: rtl/tlp_demux_n_if.sv
// Streaming bus of the N-way TLP demultiplexer: one input lane, PORTS output lanes.
interface tlp_demux_n_if #(
  parameter int PORTS        = 3,
  parameter int HEADER_SIZE  = 128,
  parameter int PAYLOAD_SIZE = 256
);
  logic [PAYLOAD_SIZE-1:0]       in_data;
  logic [HEADER_SIZE-1:0]        in_hdr;
  logic                          in_sop;
  logic                          in_eop;
  logic                          in_valid;
  logic                          in_ready;
  logic [PORTS*PAYLOAD_SIZE-1:0] out_data;
  logic [PORTS*HEADER_SIZE-1:0]  out_hdr;
  logic [PORTS-1:0]              out_sop;
  logic [PORTS-1:0]              out_eop;
  logic [PORTS-1:0]              out_valid;
  logic [PORTS-1:0]              out_ready;

  // Traffic source and sink side.
  modport master (
    output in_data, in_hdr, in_sop, in_eop, in_valid, out_ready,
    input  in_ready, out_data, out_hdr, out_sop, out_eop, out_valid
  );

  // Demultiplexer side.
  modport slave (
    input  in_data, in_hdr, in_sop, in_eop, in_valid, out_ready,
    output in_ready, out_data, out_hdr, out_sop, out_eop, out_valid
  );
endinterface

// File: rtl/tlp_demux_n.sv
// N-way TLP demultiplexer: decodes Fmt/Type on SOP, steers the whole frame to the
// first matching port through a 2-entry skid buffer, and counts drops and framing errors.
module tlp_demux_n #(
  parameter int                 PORTS        = 3,
  parameter int                 DOUBLE_WORD  = 32,
  parameter int                 HEADER_SIZE  = 4 * DOUBLE_WORD,
  parameter int                 PAYLOAD_SIZE = 8 * DOUBLE_WORD,
  parameter logic [PORTS*8-1:0] ROUTE_VAL    = 24'h0A_40_00,
  parameter logic [PORTS*8-1:0] ROUTE_MASK   = 24'hBF_DF_DF,
  parameter int                 CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  tlp_demux_n_if.slave         bus,
  output logic [CNT_WIDTH-1:0] drop_cnt,
  output logic [CNT_WIDTH-1:0] err_cnt
);

  localparam int SEL_W = (PORTS > 1) ? $clog2(PORTS) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_FWD, ST_DROP} state_t;

  typedef struct packed {
    logic [PAYLOAD_SIZE-1:0] data;
    logic [HEADER_SIZE-1:0]  hdr;
    logic                    sop;
    logic                    eop;
  } beat_t;

  state_t                 state_q, state_d;
  logic [SEL_W-1:0]       sel_q, sel_d;
  logic [HEADER_SIZE-1:0] hdr_q;
  logic                   in_ready_q;
  logic                   accept;
  logic [7:0]             ft;
  logic [PORTS-1:0]       match;
  logic                   hit;
  logic [SEL_W-1:0]       hit_idx;
  logic [PORTS-1:0]       push;
  logic                   drop_inc;
  logic                   err_inc;
  beat_t                  in_beat;

  beat_t                  out_q [PORTS];
  beat_t                  tmp_q [PORTS];
  logic [PORTS-1:0]       out_valid_q;
  logic [PORTS-1:0]       tmp_valid_q;
  logic [PORTS-1:0]       ready_early;

  assign accept = bus.in_valid && in_ready_q;
  assign ft     = bus.in_hdr[HEADER_SIZE-1 -: 8];

  // Non-SOP beats carry the header captured at the start of their frame.
  assign in_beat = {bus.in_data, (bus.in_sop ? bus.in_hdr : hdr_q), bus.in_sop, bus.in_eop};

  // Match Fmt/Type against every port; the lowest matching index wins.
  always_comb begin
    match   = '0;
    hit     = 1'b0;
    hit_idx = '0;
    for (int p = 0; p < PORTS; p++) begin
      match[p] = ((ft & ROUTE_MASK[p*8 +: 8]) == (ROUTE_VAL[p*8 +: 8] & ROUTE_MASK[p*8 +: 8]));
    end
    for (int p = PORTS - 1; p >= 0; p--) begin
      if (match[p]) begin
        hit     = 1'b1;
        hit_idx = SEL_W'(p);
      end
    end
  end

  // Frame FSM next-state, port push strobes and counter increments.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latches).
    state_d  = state_q;
    sel_d    = sel_q;
    push     = '0;
    drop_inc = 1'b0;
    err_inc  = 1'b0;
    if (accept) begin
      if (bus.in_sop) begin
        // A SOP inside a frame is a framing error; it still starts a new frame.
        if (state_q != ST_IDLE) err_inc = 1'b1;
        if (enable && hit) begin
          push[hit_idx] = 1'b1;
          sel_d         = hit_idx;
          state_d       = bus.in_eop ? ST_IDLE : ST_FWD;
        end else begin
          drop_inc = 1'b1;
          state_d  = bus.in_eop ? ST_IDLE : ST_DROP;
        end
      end else begin
        unique case (state_q)
          ST_IDLE: err_inc = 1'b1;
          ST_FWD: begin
            push[sel_q] = 1'b1;
            if (bus.in_eop) state_d = ST_IDLE;
          end
          ST_DROP: if (bus.in_eop) state_d = ST_IDLE;
          default: state_d = ST_IDLE;
        endcase
      end
    end
  end

  // A port can take a beat next cycle if it drains now or has a free slot.
  always_comb begin
    for (int p = 0; p < PORTS; p++) begin
      ready_early[p] = bus.out_ready[p] || (!tmp_valid_q[p] && (!out_valid_q[p] || !push[p]));
    end
  end

  // FSM state, SOP header, registered in_ready and saturating counters.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with <= only, so every reader sees the pre-edge value.
    if (rst) begin
      state_q    <= ST_IDLE;
      sel_q      <= '0;
      hdr_q      <= '0;
      in_ready_q <= 1'b0;
      drop_cnt   <= '0;
      err_cnt    <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      if (accept && bus.in_sop) hdr_q <= bus.in_hdr;
      // Conservative: the target port is unknown before decode, so all ports must agree.
      in_ready_q <= &ready_early;
      if (drop_inc && (drop_cnt != '1)) drop_cnt <= drop_cnt + CNT_WIDTH'(1);
      if (err_inc && (err_cnt != '1))   err_cnt  <= err_cnt + CNT_WIDTH'(1);
    end
  end

  // Per-port skid buffer: output register plus one overflow slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the beat registers are cleared because the outputs must read zero after reset.
      for (int p = 0; p < PORTS; p++) begin
        out_q[p] <= '0;
        tmp_q[p] <= '0;
      end
      out_valid_q <= '0;
      tmp_valid_q <= '0;
    end else begin
      for (int p = 0; p < PORTS; p++) begin
        if (bus.out_ready[p] || !out_valid_q[p]) begin
          // tmp is only full while in_ready is low, so it never competes with a push here.
          if (tmp_valid_q[p]) begin
            out_q[p]       <= tmp_q[p];
            out_valid_q[p] <= 1'b1;
            tmp_valid_q[p] <= 1'b0;
          end else begin
            out_valid_q[p] <= push[p];
            if (push[p]) out_q[p] <= in_beat;
          end
        end else if (push[p]) begin
          tmp_q[p]       <= in_beat;
          tmp_valid_q[p] <= 1'b1;
        end
      end
    end
  end

  // Flatten the per-port registers onto the packed output buses.
  always_comb begin
    bus.out_data  = '0;
    bus.out_hdr   = '0;
    bus.out_sop   = '0;
    bus.out_eop   = '0;
    for (int p = 0; p < PORTS; p++) begin
      bus.out_data[p*PAYLOAD_SIZE +: PAYLOAD_SIZE] = out_q[p].data;
      bus.out_hdr[p*HEADER_SIZE +: HEADER_SIZE]    = out_q[p].hdr;
      bus.out_sop[p]                               = out_q[p].sop;
      bus.out_eop[p]                               = out_q[p].eop;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.in_ready  = in_ready_q;

endmodule

// File: tb/tb_tlp_demux_n.sv
// Directed scoreboard bench for tlp_demux_n: expected beats are queued per port as
// they are accepted and a negedge monitor compares every transfer on each output.
module tb_tlp_demux_n;

  localparam int PORTS = 3;
  localparam int HS    = 128;
  localparam int PS    = 256;
  localparam int BW    = PS + HS + 2;

  typedef struct packed {
    logic [PS-1:0] data;
    logic [HS-1:0] hdr;
    logic          sop;
    logic          eop;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] drop_cnt;
  logic [15:0] err_cnt;

  int checks = 0;
  int errors = 0;

  beat_t         exp_q [PORTS][$];
  beat_t         mon_act;
  beat_t         mon_exp;
  logic [HS-1:0] frame_hdr;
  int            w;

  tlp_demux_n_if #(.PORTS(PORTS), .HEADER_SIZE(HS), .PAYLOAD_SIZE(PS)) bus ();

  tlp_demux_n #(.PORTS(PORTS)) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (en),
    .bus      (bus.slave),
    .drop_cnt (drop_cnt),
    .err_cnt  (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_val(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [PS-1:0] mk_data(input logic [31:0] tag);
    return {8{tag}};
  endfunction

  function automatic logic [HS-1:0] mk_hdr(input logic [7:0] ft, input logic [31:0] tag);
    return {ft, 24'h00_0001, tag, 64'h1234_5678_9ABC_DEF0};
  endfunction

  // Present one beat; non-SOP beats carry a junk header that must not reach the output.
  task automatic drive_beat(input logic [31:0] tag, input logic [7:0] ft, input logic sop,
                            input logic eop);
    bus.in_data  = mk_data(tag);
    bus.in_sop   = sop;
    bus.in_eop   = eop;
    bus.in_valid = 1'b1;
    if (sop) begin
      bus.in_hdr = mk_hdr(ft, tag);
      frame_hdr  = bus.in_hdr;
    end else begin
      bus.in_hdr = mk_hdr(8'h42, ~tag);
    end
  endtask

  // Wait (bounded) for the presented beat to be taken; queue it for the expected port.
  task automatic accept_beat(input int port, output int waits);
    beat_t b;
    waits = 0;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      waits++;
      if (waits > 50) begin
        check_val("accept timeout in_ready", int'(bus.in_ready), 1);
        break;
      end
    end
    @(posedge clk);
    #1;
    b = {bus.in_data, frame_hdr, bus.in_sop, bus.in_eop};
    if (port >= 0 && waits <= 50) exp_q[port].push_back(b);
    bus.in_valid = 1'b0;
  endtask

  task automatic send(input logic [31:0] tag, input logic [7:0] ft, input logic sop,
                      input logic eop, input int port, output int waits);
    drive_beat(tag, ft, sop, eop);
    accept_beat(port, waits);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every output transfer must match the head of that port's queue.
  always @(negedge clk) begin
    if (!rst) begin
      for (int p = 0; p < PORTS; p++) begin
        if (bus.out_valid[p] && bus.out_ready[p]) begin
          mon_act = {bus.out_data[p*PS +: PS], bus.out_hdr[p*HS +: HS],
                     bus.out_sop[p], bus.out_eop[p]};
          if (exp_q[p].size() == 0) begin
            check_val($sformatf("p%0d unexpected beat", p), int'(bus.out_valid[p]), 0);
          end else begin
            mon_exp = exp_q[p].pop_front();
            check($sformatf("p%0d beat", p), mon_act, mon_exp);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    en            = 1'b1;
    bus.in_data   = '0;
    bus.in_hdr    = '0;
    bus.in_sop    = 1'b0;
    bus.in_eop    = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 3'b111;
    frame_hdr     = '0;

    // Reset state.
    repeat (3) step();
    @(negedge clk);
    check_val("reset in_ready", int'(bus.in_ready), 0);
    check_val("reset out_valid", int'(bus.out_valid), 0);
    check_val("reset out_sop", int'(bus.out_sop), 0);
    check_val("reset drop_cnt", int'(drop_cnt), 0);
    check_val("reset err_cnt", int'(err_cnt), 0);
    step();
    rst = 1'b0;
    step();
    @(negedge clk);
    check_val("post-reset in_ready", int'(bus.in_ready), 1);
    step();

    // Single-beat MRd to port 0, one cycle latency.
    send(32'h1000_0001, 8'h20, 1'b1, 1'b1, 0, w);
    @(negedge clk);
    check_val("mrd out_valid", int'(bus.out_valid), 3'b001);
    check_val("mrd drop_cnt", int'(drop_cnt), 0);
    step();

    // 3-beat MWr to port 1 at full rate.
    send(32'h2000_0001, 8'h60, 1'b1, 1'b0, 1, w);
    check_val("mwr beat1 stall", w, 0);
    send(32'h2000_0002, 8'h60, 1'b0, 1'b0, 1, w);
    check_val("mwr beat2 stall", w, 0);
    send(32'h2000_0003, 8'h60, 1'b0, 1'b1, 1, w);
    check_val("mwr beat3 stall", w, 0);
    repeat (2) step();

    // CplD to port 2 with port 2 stalled: first beat held, second in tmp, input blocked.
    bus.out_ready = 3'b011;
    send(32'h3000_0001, 8'h4A, 1'b1, 1'b0, 2, w);
    send(32'h3000_0002, 8'h4A, 1'b0, 1'b0, 2, w);
    check_val("cpld beat2 accepted at once", w, 0);
    drive_beat(32'h3000_0003, 8'h4A, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("stall in_ready", int'(bus.in_ready), 0);
      check_val("stall out_valid2", int'(bus.out_valid[2]), 1);
      check("stall port2 holds beat1",
            {bus.out_data[2*PS +: PS], bus.out_hdr[2*HS +: HS], bus.out_sop[2], bus.out_eop[2]},
            {mk_data(32'h3000_0001), mk_hdr(8'h4A, 32'h3000_0001), 1'b1, 1'b0});
    end
    step();
    bus.out_ready = 3'b111;
    accept_beat(2, w);
    repeat (3) step();

    // IO write matches no port: dropped and counted; following MRd still routes.
    send(32'h4000_0001, 8'h42, 1'b1, 1'b0, -1, w);
    send(32'h4000_0002, 8'h42, 1'b0, 1'b1, -1, w);
    @(negedge clk);
    check_val("io drop_cnt", int'(drop_cnt), 1);
    step();
    send(32'h4000_0003, 8'h20, 1'b1, 1'b1, 0, w);
    repeat (2) step();

    // Disabled at SOP: whole frame dropped even though enable returns mid-frame.
    en = 1'b0;
    send(32'h5000_0001, 8'h60, 1'b1, 1'b0, -1, w);
    en = 1'b1;
    send(32'h5000_0002, 8'h60, 1'b0, 1'b0, -1, w);
    send(32'h5000_0003, 8'h60, 1'b0, 1'b1, -1, w);
    @(negedge clk);
    check_val("disabled drop_cnt", int'(drop_cnt), 2);
    step();
    send(32'h5000_0004, 8'h60, 1'b1, 1'b0, 1, w);
    send(32'h5000_0005, 8'h60, 1'b0, 1'b1, 1, w);
    @(negedge clk);
    check_val("after drops err_cnt", int'(err_cnt), 0);
    step();

    // SOP during a port-1 frame: framing error, new frame routed by its own header.
    send(32'h6000_0001, 8'h60, 1'b1, 1'b0, 1, w);
    send(32'h6000_0002, 8'h20, 1'b1, 1'b1, 0, w);
    @(negedge clk);
    check_val("sop-in-frame err_cnt", int'(err_cnt), 1);
    check_val("sop-in-frame drop_cnt", int'(drop_cnt), 2);
    repeat (2) step();

    // Reset mid-frame with beats buffered on a stalled port.
    bus.out_ready = 3'b101;
    send(32'h7000_0001, 8'h60, 1'b1, 1'b0, 1, w);
    send(32'h7000_0002, 8'h60, 1'b0, 1'b0, 1, w);
    rst = 1'b1;
    step();
    @(negedge clk);
    check_val("mid-frame reset out_valid", int'(bus.out_valid), 0);
    check_val("mid-frame reset in_ready", int'(bus.in_ready), 0);
    check_val("mid-frame reset drop_cnt", int'(drop_cnt), 0);
    check_val("mid-frame reset err_cnt", int'(err_cnt), 0);
    for (int p = 0; p < PORTS; p++) exp_q[p].delete();
    step();
    rst = 1'b0;
    bus.out_ready = 3'b111;
    step();
    @(negedge clk);
    check_val("after reset in_ready", int'(bus.in_ready), 1);
    step();
    // A fresh SOP must not be flagged: the FSM is back in IDLE.
    send(32'h7000_0003, 8'h20, 1'b1, 1'b1, 0, w);
    @(negedge clk);
    check_val("after reset out_valid", int'(bus.out_valid), 3'b001);
    check_val("after reset err_cnt", int'(err_cnt), 0);
    repeat (4) step();

    for (int p = 0; p < PORTS; p++) begin
      check_val($sformatf("p%0d queue drained", p), exp_q[p].size(), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
